// File: rtl/uncached_dreq_ctrl_if.sv
// Pipeline-side and bus-side signal bundle for the uncached data-request controller.
// The master modport is the controller's view; the slave modport is the MEM stage
// together with the SRAM-like bus wrapper.
interface uncached_dreq_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // MEM-stage request side
  logic                  pipe_req;
  logic                  pipe_wr;
  logic [ADDR_W-1:0]     pipe_addr;
  logic [2:0]            pipe_size;
  logic [DATA_W-1:0]     pipe_wdata;
  logic [DATA_W/8-1:0]   pipe_wstrb;
  logic                  pipe_ack;
  logic                  pipe_cancel;
  logic                  stall;
  logic [DATA_W-1:0]     drdata_uncached;
  logic                  rvalid;

  // SRAM-like data bus side
  logic                  bus_req;
  logic                  bus_wr;
  logic [1:0]            bus_size;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_wstrb;
  logic                  bus_addr_ok;
  logic                  bus_data_ok;
  logic [DATA_W-1:0]     bus_rdata;

  modport master (
    input  pipe_req, pipe_wr, pipe_addr, pipe_size, pipe_wdata, pipe_wstrb,
    input  pipe_ack, pipe_cancel,
    output stall, drdata_uncached, rvalid,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    output pipe_req, pipe_wr, pipe_addr, pipe_size, pipe_wdata, pipe_wstrb,
    output pipe_ack, pipe_cancel,
    input  stall, drdata_uncached, rvalid,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/uncached_dreq_ctrl.sv
// Uncached data-request controller: sequences one MEM-stage uncached access at a
// time onto the single-outstanding SRAM-like data bus, stalls the pipeline while
// the access is in flight and holds the captured read word until the pipeline
// acknowledges it.
// Optional build macro: UNCACHED_WPOST_EN -- when defined, stores are posted
// (the pipeline does not wait for them); when undefined, stores stall until the
// data phase completes, exactly like loads.
module uncached_dreq_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  uncached_dreq_ctrl_if.master io
);

`ifdef UNCACHED_WPOST_EN
  localparam bit WPOST = 1'b1;
`else
  localparam bit WPOST = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  drop_q, drop_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_wr_q, bus_wr_d;
  logic [1:0]            bus_size_q, bus_size_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]     bus_wdata_q, bus_wdata_d;
  logic [DATA_W/8-1:0]   bus_wstrb_q, bus_wstrb_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  // The in-flight transaction is a posted store: the pipeline already moved on,
  // so cancels no longer belong to it and no HOLD/ack handshake follows.
  logic posted;
  logic kill;
  logic eff_drop;
  logic req_take;
  logic done;
  logic is_word;

  assign posted   = WPOST & bus_wr_q;
  assign kill     = io.pipe_cancel & ~posted;
  // A cancel that lands in the completing cycle must still suppress the result.
  assign eff_drop = drop_q | kill;
  assign req_take = io.pipe_req & ~io.pipe_cancel;
  // Completion covers the combined address+data handshake in ADDR as well.
  assign done     = io.bus_data_ok &
                    (((state_q == ADDR) & io.bus_addr_ok) | (state_q == DATA));
  // Word-class accesses (LW/LWL/LWR/SW/SWL/SWR) go out word-aligned; the
  // downstream merge still sees the original low address bits.
  assign is_word  = (io.pipe_size == 3'd2);

  // State register: all controller state and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_size_q  <= 2'd0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      bus_req_q   <= bus_req_d;
      bus_wr_q    <= bus_wr_d;
      bus_size_q  <= bus_size_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // Next-state logic: request latch, bus handshake progress, completion and cancel.
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    bus_wr_d    = bus_wr_q;
    bus_size_d  = bus_size_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    rdata_d     = rdata_q;
    rvalid_d    = rvalid_q;

    if (done) begin
      if (eff_drop) begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end else if (posted) begin
        state_d = IDLE;
      end else begin
        state_d = HOLD;
        if (!bus_wr_q) begin
          rdata_d  = io.bus_rdata;
          rvalid_d = 1'b1;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (req_take) begin
            state_d     = ADDR;
            bus_wr_d    = io.pipe_wr;
            bus_size_d  = is_word ? 2'd2 : io.pipe_size[1:0];
            bus_addr_d  = is_word ? {io.pipe_addr[ADDR_W-1:2], 2'b00} : io.pipe_addr;
            bus_wdata_d = io.pipe_wdata;
            bus_wstrb_d = io.pipe_wstrb;
          end
        end
        ADDR: begin
          if (io.bus_addr_ok) begin
            state_d = DATA;
            drop_d  = eff_drop;
          end else if (kill) begin
            // Nothing reached the bus yet, so the request can simply vanish.
            state_d = IDLE;
          end
        end
        DATA: begin
          // The bus owes us a data phase; remember a cancel and swallow it later.
          drop_d = eff_drop;
        end
        HOLD: begin
          if (io.pipe_ack || io.pipe_cancel) begin
            state_d  = IDLE;
            rvalid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    bus_req_d = (state_d == ADDR);
  end

  // Output logic: combinational stall plus the registered bus/result outputs.
  always_comb begin
    io.stall = 1'b0;
    case (state_q)
      IDLE:       io.stall = io.pipe_req & ~io.pipe_cancel & ~(WPOST & io.pipe_wr);
      ADDR, DATA: io.stall = posted ? io.pipe_req : 1'b1;
      default:    io.stall = 1'b0;
    endcase
    io.bus_req         = bus_req_q;
    io.bus_wr          = bus_wr_q;
    io.bus_size        = bus_size_q;
    io.bus_addr        = bus_addr_q;
    io.bus_wdata       = bus_wdata_q;
    io.bus_wstrb       = bus_wstrb_q;
    io.drdata_uncached = rdata_q;
    io.rvalid          = rvalid_q;
  end

endmodule

// File: tb/tb_uncached_dreq_ctrl.sv
// Scoreboard bench for uncached_dreq_ctrl: the driver pushes expected bus
// transactions and load results; a monitor pops and compares them whenever the
// DUT accepts an address phase or presents rvalid. A bus responder with its own
// memory answers the DUT; the driver keeps an independent memory model.
module tb_uncached_dreq_ctrl;

`ifdef UNCACHED_WPOST_EN
  localparam bit WPOST = 1'b1;
`else
  localparam bit WPOST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uncached_dreq_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  uncached_dreq_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bif)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_txn_t;

  bus_txn_t    exp_bus_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] model_mem [logic [29:0]];
  logic [31:0] bus_mem   [logic [29:0]];

  function automatic logic [31:0] mem_init(input logic [29:0] w);
    return {w[13:0], w[17:0]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [29:0] w);
    return model_mem.exists(w) ? model_mem[w] : mem_init(w);
  endfunction

  function automatic logic [31:0] busmem_rd(input logic [29:0] w);
    return bus_mem.exists(w) ? bus_mem[w] : mem_init(w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] v);
    model_mem[addr[31:2]] = v;
    bus_mem[addr[31:2]]   = v;
  endtask

  // ---------------- bus responder ----------------
  int          addr_lat_cfg = 0;
  int          data_lat_cfg = 0;
  bit          rand_lat = 1'b0;
  logic        r_wr;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_wstrb;

  task automatic respond();
    bif.bus_data_ok = 1'b1;
    if (r_wr) bus_mem[r_addr[31:2]] = merge(busmem_rd(r_addr[31:2]), r_wdata, r_wstrb);
    else      bif.bus_rdata = busmem_rd(r_addr[31:2]);
  endtask

  initial begin
    int  cnt = 0, dcnt = 0, alat = 0, dlat = 0;
    bit  waiting = 1'b0;
    bif.bus_addr_ok = 1'b0;
    bif.bus_data_ok = 1'b0;
    bif.bus_rdata   = '0;
    forever begin
      @(posedge clk); #1;
      bif.bus_addr_ok = 1'b0;
      bif.bus_data_ok = 1'b0;
      bif.bus_rdata   = $urandom;
      if (waiting) begin
        dcnt++;
        if (dcnt >= dlat) begin
          respond();
          waiting = 1'b0;
        end
      end else if (bif.bus_req) begin
        if (cnt == 0) begin
          alat = rand_lat ? int'($urandom_range(0, 3)) : addr_lat_cfg;
          dlat = rand_lat ? int'($urandom_range(0, 3)) : data_lat_cfg;
        end
        if (cnt >= alat) begin
          bif.bus_addr_ok = 1'b1;
          r_wr = bif.bus_wr; r_addr = bif.bus_addr;
          r_wdata = bif.bus_wdata; r_wstrb = bif.bus_wstrb;
          cnt = 0;
          if (dlat == 0) respond();
          else begin
            waiting = 1'b1;
            dcnt = 0;
          end
        end else cnt++;
      end else cnt = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit          rv_prev = 1'b0;
  logic [31:0] cur_rd = '0;

  always @(negedge clk) begin
    bus_txn_t t;
    if (rst) rv_prev = 1'b0;
    else begin
      if (bif.bus_req && bif.bus_addr_ok) begin
        if (exp_bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_txn: got unexpected address phase addr=0x%08h required none", bif.bus_addr);
        end else begin
          t = exp_bus_q.pop_front();
          chk("bus_wr", 32'(bif.bus_wr), 32'(t.wr));
          chk("bus_addr", bif.bus_addr, t.addr);
          chk("bus_size", 32'(bif.bus_size), 32'(t.size));
          if (t.wr) begin
            chk("bus_wdata", bif.bus_wdata, t.wdata);
            chk("bus_wstrb", 32'(bif.bus_wstrb), 32'(t.wstrb));
          end
        end
      end
      if (bif.rvalid && !rv_prev) begin
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rvalid: got unexpected rvalid data=0x%08h required none", bif.drdata_uncached);
        end else cur_rd = exp_rd_q.pop_front();
      end
      if (bif.rvalid) chk("drdata_uncached", bif.drdata_uncached, cur_rd);
      rv_prev = bif.rvalid;
    end
  end

  // ---------------- driver ----------------
  int txn_no = 0;

  task automatic push_bus(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    bus_txn_t t;
    t.wr    = wr;
    t.addr  = (size == 3'd2) ? {addr[31:2], 2'b00} : addr;
    t.size  = (size == 3'd2) ? 2'd2 : size[1:0];
    t.wdata = wdata;
    t.wstrb = wstrb;
    exp_bus_q.push_back(t);
  endtask

  task automatic drive(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    bif.pipe_req = 1'b1; bif.pipe_wr = wr; bif.pipe_addr = addr; bif.pipe_size = size;
    bif.pipe_wdata = wdata; bif.pipe_wstrb = wstrb; bif.pipe_ack = 1'b0; bif.pipe_cancel = 1'b0;
  endtask

  // Full request: issue, wait for stall to release, acknowledge (unless posted).
  // Called and returns just after a rising edge.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int ack_delay, output int stall_cycles);
    txn_no++;
    $display("txn %0d: %s addr=0x%08h size=%0d wdata=0x%08h wstrb=%b",
             txn_no, wr ? "store" : "load ", addr, size, wdata, wstrb);
    drive(wr, addr, size, wdata, wstrb);
    push_bus(wr, addr, size, wdata, wstrb);
    if (wr) model_mem[addr[31:2]] = merge(model_rd(addr[31:2]), wdata, wstrb);
    else    exp_rd_q.push_back(model_rd(addr[31:2]));
    stall_cycles = 0;
    forever begin
      @(negedge clk);
      if (!bif.stall) break;
      stall_cycles++;
      if (stall_cycles > 200) begin
        checks++; errors++;
        $display("FAIL stall_timeout: got stall stuck high required release within 200 cycles");
        break;
      end
      @(posedge clk); #1;
    end
    if (wr && WPOST) begin
      @(posedge clk); #1;
      bif.pipe_req = 1'b0;
    end else begin
      chk("rvalid_at_done", 32'(bif.rvalid), 32'(!wr));
      repeat (ack_delay + 1) @(posedge clk);
      #1;
      bif.pipe_ack = 1'b1;
      bif.pipe_req = 1'b0;
      @(posedge clk); #1;
      bif.pipe_ack = 1'b0;
      @(negedge clk);
      chk("rvalid_after_ack", 32'(bif.rvalid), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic set_lat(input int a, input int d);
    rand_lat = 1'b0; addr_lat_cfg = a; data_lat_cfg = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bus_req"},   32'(bif.bus_req), 32'd0);
    chk({tag, "_bus_wr"},    32'(bif.bus_wr), 32'd0);
    chk({tag, "_bus_size"},  32'(bif.bus_size), 32'd0);
    chk({tag, "_bus_addr"},  bif.bus_addr, 32'd0);
    chk({tag, "_bus_wdata"}, bif.bus_wdata, 32'd0);
    chk({tag, "_bus_wstrb"}, 32'(bif.bus_wstrb), 32'd0);
    chk({tag, "_drdata"},    bif.drdata_uncached, 32'd0);
    chk({tag, "_rvalid"},    32'(bif.rvalid), 32'd0);
    chk({tag, "_stall"},     32'(bif.stall), 32'd0);
  endtask

  initial begin
    int sc;
    rst = 1'b1;
    bif.pipe_req = 1'b0; bif.pipe_wr = 1'b0; bif.pipe_addr = '0; bif.pipe_size = '0;
    bif.pipe_wdata = '0; bif.pipe_wstrb = '0; bif.pipe_ack = 1'b0; bif.pipe_cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;

    // Word load, addr_ok in the 2nd address cycle, data_ok 3 cycles later.
    preload(32'h1FC0_0004, 32'hDEAD_BEEF);
    set_lat(1, 3);
    do_req(1'b0, 32'h1FC0_0004, 3'd2, 32'h0, 4'h0, 2, sc);
    chk("load_word_stall_cycles", sc, 6);

    // LWL and byte load address formation.
    set_lat(0, 1);
    do_req(1'b0, 32'hBFD0_0003, 3'd2, 32'h0, 4'h0, 0, sc);
    chk("lwl_stall_cycles", sc, 3);
    do_req(1'b0, 32'hBFD0_0002, 3'd0, 32'h0, 4'h0, 1, sc);

    // Address and data phase in the same cycle: ADDR straight to HOLD.
    set_lat(0, 0);
    do_req(1'b0, 32'hBFD0_0010, 3'd2, 32'h0, 4'h0, 0, sc);
    chk("same_cycle_stall_cycles", sc, 2);

    // Store, then a load that depends on it.
    set_lat(0, 1);
    do_req(1'b1, 32'hBFD0_0020, 3'd2, 32'h1234_5678, 4'hF, 0, sc);
    chk("store_stall_cycles", sc, WPOST ? 0 : 3);
    do_req(1'b0, 32'hBFD0_0020, 3'd2, 32'h0, 4'h0, 0, sc);
    chk("load_after_store_stall_cycles", sc, WPOST ? 5 : 3);

    // Randomized mix of loads and stores with random bus latencies.
    rand_lat = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      wr   = ($urandom_range(0, 2) == 0);
      size = 3'($urandom_range(0, 2));
      addr = 32'hBFD0_0000 | 32'($urandom_range(0, 31));
      do_req(wr, addr, size, $urandom, 4'($urandom_range(1, 15)),
             int'($urandom_range(0, 2)), sc);
    end

    // Cancel in ADDR before addr_ok: request vanishes, no bus transaction.
    set_lat(4, 0);
    drive(1'b0, 32'hBFD0_0040, 3'd2, 32'h0, 4'h0);
    @(posedge clk); #1;
    bif.pipe_cancel = 1'b1; bif.pipe_req = 1'b0;
    @(negedge clk);
    chk("cancel_addr_stall", 32'(bif.stall), 32'd1);
    @(posedge clk); #1;
    bif.pipe_cancel = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("cancel_addr_no_bus_req", 32'(bif.bus_req), 32'd0);
      @(posedge clk); #1;
    end

    // Cancel in DATA: stall holds until data_ok, result is dropped.
    set_lat(0, 3);
    drive(1'b0, 32'hBFD0_0044, 3'd2, 32'h0, 4'h0);
    push_bus(1'b0, 32'hBFD0_0044, 3'd2, 32'h0, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bif.pipe_cancel = 1'b1; bif.pipe_req = 1'b0;
    sc = 0;
    forever begin
      @(negedge clk);
      if (!bif.stall || sc > 50) break;
      sc++;
      @(posedge clk); #1;
      bif.pipe_cancel = 1'b0;
    end
    chk("cancel_data_stall_cycles", sc, 3);
    repeat (3) begin
      chk("cancel_data_rvalid", 32'(bif.rvalid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Reset asserted in DATA: outputs return to reset values, late data_ok ignored.
    set_lat(0, 4);
    drive(1'b0, 32'hBFD0_0048, 3'd2, 32'h0, 4'h0);
    push_bus(1'b0, 32'hBFD0_0048, 3'd2, 32'h0, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; bif.pipe_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_in_data");
    repeat (6) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("late_data_ok_rvalid", 32'(bif.rvalid), 32'd0);
      chk("late_data_ok_bus_req", 32'(bif.bus_req), 32'd0);
    end
    @(posedge clk); #1;

    // Controller still works after the mid-transaction reset.
    set_lat(0, 1);
    do_req(1'b0, 32'hBFD0_004C, 3'd2, 32'h0, 4'h0, 0, sc);
    chk("post_reset_load_stall_cycles", sc, 3);

    repeat (3) @(posedge clk);
    chk("bus_queue_drained", 32'(exp_bus_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running required completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uncached_dreq_ctrl.md
Name: uncached_dreq_ctrl

Overview:
Sequences uncached data-memory accesses from the MEM stage onto the single-outstanding SRAM-like data bus.
- Latches the pipeline request, drives the bus address and data phases, and stalls the pipeline while the access is in flight.
- Captures and holds the read word that the pre-writeback extract/merge logic consumes as its uncached read-data input.
- Owns the only path to the uncached bus port; cached accesses never reach this block.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed at 32; the wstrb width is DATA_W/8)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
pipe_req  in  1  uncached access request from MEM stage, held until pipe_ack or pipe_cancel
pipe_wr  in  1  1 = store, 0 = load
pipe_addr  in  32  byte address
pipe_size  in  3  0 = byte, 1 = half, 2 = word/LWL/LWR/SWL/SWR
pipe_wdata  in  32  store data, already lane-aligned
pipe_wstrb  in  4  store byte enables
pipe_ack  in  1  pipeline has consumed the result and advanced
pipe_cancel  in  1  exception/flush; kill the current request
stall  out  1  freeze MEM and earlier stages
drdata_uncached  out  32  held read word
rvalid  out  1  drdata_uncached valid for the current load
bus_req  out  1  bus request
bus_wr  out  1  bus write
bus_size  out  2  bus transfer size
bus_addr  out  32  bus address
bus_wdata  out  32  bus write data
bus_wstrb  out  4  bus byte enables
bus_addr_ok  in  1  address phase accepted
bus_data_ok  in  1  data phase complete
bus_rdata  in  32  read data, valid with bus_data_ok

Behaviour:
- FSM states: IDLE, ADDR, DATA, HOLD. A one-bit drop flag accompanies them.
- Reset: state=IDLE, drop=0, bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, drdata_uncached=0, rvalid=0.
- A bus_data_ok arriving after reset is ignored. The bus wrapper must not issue a response for a transaction killed by reset.
- IDLE:
  - pipe_req=1 and pipe_cancel=0 -> latch wr/addr/size/wdata/wstrb; next state ADDR.
  - bus_req goes high the next cycle (registered outputs).
- Address formation:
  - pipe_size=2 -> bus_addr[1:0]=00 and bus_size=2; the downstream LWL/LWR merge uses the original addr[1:0].
  - Otherwise bus_addr=pipe_addr and bus_size=pipe_size[1:0].
- ADDR: bus_req=1.
  - bus_addr_ok=1 -> DATA, and bus_req drops the next cycle.
  - bus_addr_ok and bus_data_ok high in the same cycle -> complete directly (see completion).
- DATA: bus_req=0; wait for bus_data_ok.
- Completion (bus_data_ok):
  - Load, drop=0 -> capture bus_rdata into drdata_uncached, rvalid=1, go to HOLD.
  - Store -> go to HOLD, rvalid stays 0.
  - drop=1 -> go to IDLE, drop cleared, no rvalid.
- HOLD: stall=0; drdata_uncached and rvalid are held stable.
  - pipe_ack=1 -> IDLE; rvalid clears in the same transition.
  - A new request is not sampled in HOLD.
- stall = (IDLE & pipe_req & ~pipe_cancel) | ADDR | DATA. stall is combinational, so a request stalls in its first cycle.
- pipe_cancel:
  - In IDLE: no effect.
  - In ADDR without bus_addr_ok that cycle: go to IDLE, bus_req drops, no bus transaction.
  - In ADDR with bus_addr_ok, or in DATA: set drop=1 and keep waiting for bus_data_ok; stall stays high until it arrives.
  - In HOLD: go to IDLE and clear rvalid.
- bus_data_ok in IDLE or HOLD: ignored.
- Only one transaction is outstanding at any time.

Optional Feature:
Macro: UNCACHED_WPOST_EN
- Defined: stores are posted. In IDLE a store request is latched and stall stays 0 that cycle. The pipeline treats the store as done, with no HOLD and no pipe_ack needed. The bus transaction proceeds through ADDR/DATA and returns to IDLE on bus_data_ok. pipe_cancel does not affect a posted store. Any pipe_req while a posted store is in flight stalls until it reaches IDLE. Loads behave as described above.
- Undefined: stores stall until bus_data_ok, then go to HOLD as described.

Test Plan:
- Load word at 0x1FC0_0004, addr_ok after 2 cycles, data_ok 3 cycles later with rdata 0xDEADBEEF -> bus_addr=0x1FC00004, bus_size=2, stall high for 6 cycles, then rvalid=1 and drdata_uncached=0xDEADBEEF held until pipe_ack.
- LWL at 0xBFD0_0003 -> bus_addr=0xBFD00000, bus_size=2.
- Byte load at 0xBFD0_0002 -> bus_addr=0xBFD00002, bus_size=0.
- bus_addr_ok and bus_data_ok asserted in the same cycle -> goes from ADDR to HOLD in one step; drdata_uncached equals bus_rdata.
- Store 0x12345678 with wstrb=1111 -> bus_wr=1 and bus_wdata=0x12345678.
  - Macro off: stall held until data_ok.
  - Macro on: stall=0 in the request cycle; a following load stalls until the store's data_ok.
- pipe_cancel in ADDR before addr_ok -> IDLE, no further bus_req.
- pipe_cancel in DATA -> stall stays high until data_ok, then rvalid=0 and state IDLE.
- rst asserted in DATA -> all outputs return to their reset values the next cycle; a late data_ok is ignored.
